// File: rtl/modulo_counter_bank_pkg.sv
// Shared moduli and output widths for the modulo counter bank.
// Optional terminal-count outputs are enabled with MODCNT_TC_EN.
package modulo_counter_pkg;

  localparam int MOD3  = 3;
  localparam int MOD5  = 5;
  localparam int MOD7  = 7;
  localparam int MOD8  = 8;
  localparam int MOD16 = 16;

  localparam int W3  = 4;
  localparam int W5  = 5;
  localparam int W7  = 3;
  localparam int W8  = 3;
  localparam int W16 = 4;

endpackage

// File: rtl/modulo_counter_bank_if.sv
// Count bus of the modulo counter bank; the bank drives it through the master modport.
// Terminal-count lines exist only when MODCNT_TC_EN is defined.
interface modulo_counter_bank_if;
  import modulo_counter_pkg::*;

  logic [W3-1:0]  mod_3;
  logic [W5-1:0]  mod_5;
  logic [W7-1:0]  mod_7;
  logic [W8-1:0]  mod_8;
  logic [W16-1:0] mod_16;
`ifdef MODCNT_TC_EN
  logic           tc_3;
  logic           tc_5;
  logic           tc_7;
  logic           tc_8;
  logic           tc_16;
`endif

  modport master (
    output mod_3, mod_5, mod_7, mod_8, mod_16
`ifdef MODCNT_TC_EN
    , output tc_3, tc_5, tc_7, tc_8, tc_16
`endif
  );

  modport slave (
    input mod_3, mod_5, mod_7, mod_8, mod_16
`ifdef MODCNT_TC_EN
    , input tc_3, tc_5, tc_7, tc_8, tc_16
`endif
  );

endinterface

// File: rtl/modulo_counter_bank_mod_n_counter.sv
// Free-running mod-N counter with registered output of width W.
// The tc port (count == N-1, gated by rst) exists only when MODCNT_TC_EN is defined.
module mod_n_counter #(
  parameter int N = 3,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
`ifdef MODCNT_TC_EN
  output logic         tc,
`endif
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_count;

  // Compare with >= so any out-of-range value from an upset falls back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_count >= LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

`ifdef MODCNT_TC_EN
  assign tc = !rst && (r_count == LAST);
`endif

endmodule

// File: rtl/modulo_counter_bank.sv
// Bank of five free-running modulo counters (mod 3, 5, 7, 8, 16) sharing one clock and reset.
// Defining MODCNT_TC_EN adds a terminal-count pulse per counter.
module modulo_counter_bank
  import modulo_counter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  modulo_counter_bank_if.master cnt_if
);

  mod_n_counter #(.N(MOD3), .W(W3)) u_mod3 (
    .clk   (clk),
    .rst   (rst),
`ifdef MODCNT_TC_EN
    .tc    (cnt_if.tc_3),
`endif
    .count (cnt_if.mod_3)
  );

  mod_n_counter #(.N(MOD5), .W(W5)) u_mod5 (
    .clk   (clk),
    .rst   (rst),
`ifdef MODCNT_TC_EN
    .tc    (cnt_if.tc_5),
`endif
    .count (cnt_if.mod_5)
  );

  mod_n_counter #(.N(MOD7), .W(W7)) u_mod7 (
    .clk   (clk),
    .rst   (rst),
`ifdef MODCNT_TC_EN
    .tc    (cnt_if.tc_7),
`endif
    .count (cnt_if.mod_7)
  );

  mod_n_counter #(.N(MOD8), .W(W8)) u_mod8 (
    .clk   (clk),
    .rst   (rst),
`ifdef MODCNT_TC_EN
    .tc    (cnt_if.tc_8),
`endif
    .count (cnt_if.mod_8)
  );

  mod_n_counter #(.N(MOD16), .W(W16)) u_mod16 (
    .clk   (clk),
    .rst   (rst),
`ifdef MODCNT_TC_EN
    .tc    (cnt_if.tc_16),
`endif
    .count (cnt_if.mod_16)
  );

endmodule

// File: tb/tb_modulo_counter_bank.sv
// Directed testbench for modulo_counter_bank; exercises tc outputs when MODCNT_TC_EN is defined.
module tb_modulo_counter_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  modulo_counter_bank_if u_if ();

  modulo_counter_bank u_dut (
    .clk    (clk),
    .rst    (rst),
    .cnt_if (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string ph, input int e3, input int e5, input int e7,
                           input int e8, input int e16);
    check_val({ph, ".mod_3"},  32'(u_if.mod_3),  32'(e3));
    check_val({ph, ".mod_5"},  32'(u_if.mod_5),  32'(e5));
    check_val({ph, ".mod_7"},  32'(u_if.mod_7),  32'(e7));
    check_val({ph, ".mod_8"},  32'(u_if.mod_8),  32'(e8));
    check_val({ph, ".mod_16"}, 32'(u_if.mod_16), 32'(e16));
    $display("%s rst=%0b mod_3=%0d mod_5=%0d mod_7=%0d mod_8=%0d mod_16=%0d",
             ph, rst, u_if.mod_3, u_if.mod_5, u_if.mod_7, u_if.mod_8, u_if.mod_16);
  endtask

`ifdef MODCNT_TC_EN
  task automatic check_tc(input string ph, input logic e3, input logic e5, input logic e7,
                          input logic e8, input logic e16);
    check_val({ph, ".tc_3"},  32'(u_if.tc_3),  32'(e3));
    check_val({ph, ".tc_5"},  32'(u_if.tc_5),  32'(e5));
    check_val({ph, ".tc_7"},  32'(u_if.tc_7),  32'(e7));
    check_val({ph, ".tc_8"},  32'(u_if.tc_8),  32'(e8));
    check_val({ph, ".tc_16"}, 32'(u_if.tc_16), 32'(e16));
  endtask
`endif

  // Expected state k non-reset edges after reset.
  task automatic check_k(input string ph, input int k);
    check_all($sformatf("%s k=%0d", ph, k), k % 3, k % 5, k % 7, k % 8, k % 16);
`ifdef MODCNT_TC_EN
    check_tc($sformatf("%s k=%0d", ph, k),
             (k % 3) == 2, (k % 5) == 4, (k % 7) == 6, (k % 8) == 7, (k % 16) == 15);
`endif
  endtask

  initial begin
    // Reset held for two edges.
    rst = 1'b1;
    @(negedge clk);
    step();
    check_all("reset1", 0, 0, 0, 0, 0);
    step();
    check_all("reset2", 0, 0, 0, 0, 0);
`ifdef MODCNT_TC_EN
    check_tc("reset2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // First sixteen edges after release.
    rst = 1'b0;
    step();
    check_all("edge1", 1, 1, 1, 1, 1);
    for (int k = 2; k <= 16; k++) begin
      step();
      check_k("run16", k);
      if (k == 5)  check_all("edge5",  2, 0, 5, 5, 5);
      if (k == 7)  check_all("edge7",  1, 2, 0, 7, 7);
      if (k == 8)  check_all("edge8",  2, 3, 1, 0, 8);
      if (k == 16) check_all("edge16", 1, 1, 2, 0, 0);
    end

    for (int k = 17; k <= 104; k++) begin
      step();
      check_k("run105", k);
    end

    // At k=104 every low-modulus counter sits at N-1; asserting rst must clear tc at once.
    check_all("edge104", 2, 4, 6, 0, 8);
    rst = 1'b1;
    #1;
`ifdef MODCNT_TC_EN
    check_tc("rst_gate", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    check_all("rst_gate", 2, 4, 6, 0, 8);
    rst = 1'b0;
    step();
    check_all("edge105", 0, 0, 0, 1, 9);

    // Reset mid-run at edge 11.
    rst = 1'b1;
    step();
    check_all("rerst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) step();
    check_all("edge11", 2, 1, 4, 3, 11);
    rst = 1'b1;
    step();
    check_all("midrst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    check_all("after_midrst", 1, 1, 1, 1, 1);

    // Long run: unused bits stay low and mod_7 never shows 7.
    for (int k = 2; k <= 201; k++) begin
      step();
      check_k("run200", k);
      check_val($sformatf("k=%0d mod_3_hi", k), 32'(u_if.mod_3[3:2]), 32'd0);
      check_val($sformatf("k=%0d mod_5_hi", k), 32'(u_if.mod_5[4:3]), 32'd0);
      check_val($sformatf("k=%0d mod_7_is7", k), 32'(u_if.mod_7 == 3'd7), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulo_counter_bank.md
Name: modulo_counter_bank

Overview:
- Bank of five independent free-running modulo counters (mod 3, 5, 7, 8, 16) clocked from one clock.
- Used as a timebase/sequence source for simple divide-by-N and round-robin selection elsewhere in the design.
- No enable and no load: every counter advances on every clock edge while out of reset.

Parameters:
- None. Moduli and widths are fixed constants taken from the shared package.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high; one clock; rst sampled only at clk rising edge.
- mod_3  output  4  mod-3 count, values 0..2; bits [3:2] always 0.
- mod_5  output  5  mod-5 count, values 0..4; bits [4:3] always 0.
- mod_7  output  3  mod-7 count, values 0..6.
- mod_8  output  3  mod-8 count, values 0..7.
- mod_16  output  4  mod-16 count, values 0..15.

Behaviour:
- All outputs driven directly from registers, with no combinational path from inputs to outputs.
- Reset: rst=1 at a rising edge sets every counter to 0. Outputs stay 0 while rst is held.
- Count: each rising edge with rst=0 updates every counter as follows:
  - if value == N-1, the next value is 0;
  - otherwise the next value is value+1.
- Latency: the first edge with rst=0 after reset yields 1 on all outputs. After k non-reset edges from reset, each output equals k mod N.
- Wrap-around, per counter:
  - mod_3: 2→0.
  - mod_5: 4→0.
  - mod_7: 6→0; value 7 is never produced.
  - mod_8 and mod_16 wrap naturally (7→0, 15→0) but still use the explicit compare.
- Unused upper bits of mod_3 and mod_5 are tied to 0 and must never toggle.
- Reset mid-operation: rst=1 at any edge forces all counters to 0 on that edge, regardless of current value. Reset takes priority over counting.
- Illegal states (e.g. mod_7=7, mod_5≥5 from X/upset) must recover to 0 on the next edge. Compares use ≥ N-1, not == N-1.
- All counters share a common phase after reset: at k=0,105,210… (lcm of 3,5,7), mod_3, mod_5 and mod_7 are 0 together.

Optional Feature:
- Macro: MODCNT_TC_EN.
- Defined:
  - Adds five 1-bit outputs tc_3, tc_5, tc_7, tc_8, tc_16.
  - Each is high combinationally when its counter equals N-1 and rst=0; it is 0 during reset.
  - Each pulses one cycle in every N.
- Undefined: these ports and their logic do not exist. The counter behaviour is identical in both builds.

Decomposition:
- Package modulo_counter_pkg holds:
  - localparams MOD3=3, MOD5=5, MOD7=7, MOD8=8, MOD16=16;
  - output widths W3=4, W5=5, W7=3, W8=3, W16=4.
- One sub-module, mod_n_counter, parameterised by modulus N and width W.
  - Ports: clk, rst, count, tc.
  - Instantiated five times in the top level.

Test Plan:
- Hold rst=1 for 2 edges, then release.
  - Required: all outputs 0 during reset.
  - Required: first edge after release gives mod_3=1, mod_5=1, mod_7=1, mod_8=1, mod_16=1.
- Run 16 edges after reset.
  - Required: mod_3 sequence 1,2,0,1,…
  - Required: mod_5 sequence 1,2,3,4,0,…
  - Required: mod_7 reaches 6 then 0 at edge 7.
  - Required: mod_8 is 0 at edge 8.
  - Required: mod_16 is 0 at edge 16.
- Run 105 edges after reset.
  - Required: mod_3=0, mod_5=0, mod_7=0 simultaneously.
  - Required: mod_8=1 (105 mod 8), mod_16=9.
- Assert rst=1 for one edge at edge 11 (mod_3=2, mod_5=1, mod_7=4, mod_8=3, mod_16=11).
  - Required: all outputs 0 on the next sample, then 1 on the following edge.
- Run 200 edges.
  - Required: mod_3[3:2] and mod_5[4:3] remain 0 throughout.
  - Required: mod_7 never equals 7.
- With MODCNT_TC_EN defined, run 20 edges.
  - Required: tc_5 high exactly when mod_5=4.
  - Required: tc_16 high only when mod_16=15.
  - Required: all tc outputs are 0 while rst=1.
